// File: rtl/chargen_pkg.sv
// Shared types and sizes for the text-mode character generator CPU access path.
package chargen_pkg;

    localparam int ADDR_W       = 14;
    localparam int CH_MAP_DEPTH = 2400;
    localparam int GLYPH_COUNT  = 128;
    localparam int MAP_AW       = 12;
    localparam int GLYPH_AW     = 7;
    localparam int MAP_WORDS    = CH_MAP_DEPTH / 4;

    typedef enum logic [1:0] {
        RG_CH_MAP  = 2'b00,
        RG_COL_MAP = 2'b01,
        RG_GLYPH   = 2'b10,
        RG_NONE    = 2'b11
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BYTE,
        ST_BYTE_CAP,
        ST_GL_RD,
        ST_GL_MRG,
        ST_RESP
    } state_e;

endpackage

// File: rtl/chargen_addr_decode.sv
// Splits an APB word address into memory region, map word index, glyph/word
// selectors and an error flag for holes in the address map.
module chargen_addr_decode
    import chargen_pkg::*;
(
    input  logic [ADDR_W-1:2]   i_paddr_word,
    output region_e             o_region,
    output logic [9:0]          o_map_word,
    output logic [GLYPH_AW-1:0] o_glyph,
    output logic [1:0]          o_word,
    output logic                o_err
);

    assign o_region   = region_e'(i_paddr_word[13:12]);
    assign o_map_word = i_paddr_word[11:2];
    assign o_glyph    = i_paddr_word[10:4];
    assign o_word     = i_paddr_word[3:2];

    always_comb begin
        o_err = 1'b1;
        unique case (o_region)
            RG_CH_MAP, RG_COL_MAP: o_err = (o_map_word >= 10'(MAP_WORDS));
            RG_GLYPH:              o_err = i_paddr_word[11];
            default:               o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/apb_chargen_mem_ctrl.sv
// APB responder giving the CPU byte-packed access to the character/colour maps
// and read-modify-write access to 128-bit glyph rows.
//
// state       | meaning
// ST_IDLE     | waiting for an APB setup phase
// ST_BYTE     | walking map lanes 0..3, one map byte per cycle
// ST_BYTE_CAP | capturing the lane-3 read byte
// ST_GL_RD    | glyph row address presented
// ST_GL_MRG   | glyph row valid: merge and write back, or latch the word
// ST_RESP     | pready for one cycle
module apb_chargen_mem_ctrl
    import chargen_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_W-1:0]     paddr_i,
    input  logic [31:0]           pwdata_i,
    input  logic [3:0]            pstrb_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [MAP_AW-1:0]     ch_map_addr_o,
    output logic                  ch_map_wen_o,
    output logic [7:0]            ch_map_data_o,
    input  logic [7:0]            ch_map_data_i,
    output logic [MAP_AW-1:0]     col_map_addr_o,
    output logic                  col_map_wen_o,
    output logic [7:0]            col_map_data_o,
    input  logic [7:0]            col_map_data_i,
    output logic [GLYPH_AW-1:0]   ch_t_rw_addr_o,
    output logic                  ch_t_rw_wen_o,
    output logic [127:0]          ch_t_rw_data_o,
    input  logic [127:0]          ch_t_rw_data_i
);

    state_e               r_state, w_state_nxt;
    region_e              r_region, w_region;
    logic [9:0]           r_map_word, w_map_word;
    logic [GLYPH_AW-1:0]  r_glyph, w_glyph;
    logic [1:0]           r_word, w_word;
    logic [1:0]           r_lane;
    logic [31:0]          r_wdata, r_rdata;
    logic [3:0]           r_strb;
    logic                 r_write, r_err;
    logic                 w_err, w_setup;
    logic [1:0]           w_prev_lane;
    logic [7:0]           w_map_rd, w_lane_wbyte;
    logic [MAP_AW-1:0]    w_map_addr;
    logic [127:0]         w_merge;
    logic                 w_unused_addr;

    // Byte offset within a word carries no meaning: accesses are word-wide.
    assign w_unused_addr = ^paddr_i[1:0];
    assign w_setup       = psel_i && !penable_i;
    assign w_prev_lane   = r_lane - 2'd1;
    assign w_map_rd      = (r_region == RG_COL_MAP) ? col_map_data_i : ch_map_data_i;
    assign w_lane_wbyte  = r_wdata[{r_lane, 3'b000} +: 8];
    assign w_map_addr    = {r_map_word, r_lane};

    chargen_addr_decode u_addr_decode (
        .i_paddr_word (paddr_i[ADDR_W-1:2]),
        .o_region     (w_region),
        .o_map_word   (w_map_word),
        .o_glyph      (w_glyph),
        .o_word       (w_word),
        .o_err        (w_err)
    );

    always_comb begin
        w_merge = ch_t_rw_data_i;
        for (int b = 0; b < 4; b++) begin
            if (r_strb[b]) begin
                w_merge[{r_word, 5'b00000} + 7'(8 * b) +: 8] = r_wdata[8 * b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    if (w_err)                      w_state_nxt = ST_RESP;
                    else if (w_region == RG_GLYPH)  w_state_nxt = ST_GL_RD;
                    else                            w_state_nxt = ST_BYTE;
                end
            end
            ST_BYTE:     if (r_lane == 2'd3) w_state_nxt = r_write ? ST_RESP : ST_BYTE_CAP;
            ST_BYTE_CAP: w_state_nxt = ST_RESP;
            ST_GL_RD:    w_state_nxt = ST_GL_MRG;
            ST_GL_MRG:   w_state_nxt = ST_RESP;
            ST_RESP:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_region   <= RG_CH_MAP;
            r_map_word <= '0;
            r_glyph    <= '0;
            r_word     <= '0;
            r_lane     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_strb     <= '0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_region   <= w_region;
                        r_map_word <= w_map_word;
                        r_glyph    <= w_glyph;
                        r_word     <= w_word;
                        r_wdata    <= pwdata_i;
                        r_strb     <= pstrb_i;
                        r_write    <= pwrite_i;
                        r_err      <= w_err;
                        r_lane     <= '0;
                        r_rdata    <= '0;
                    end
                end
                ST_BYTE: begin
                    r_lane <= r_lane + 2'd1;
                    // Synchronous-read map: this cycle shows the previous lane's byte.
                    if (!r_write && r_lane != 2'd0) begin
                        r_rdata[{w_prev_lane, 3'b000} +: 8] <= w_map_rd;
                    end
                end
                ST_BYTE_CAP: if (!r_write) r_rdata[31:24] <= w_map_rd;
                ST_GL_MRG:   if (!r_write) r_rdata <= ch_t_rw_data_i[{r_word, 5'b00000} +: 32];
                default: ;
            endcase
        end
    end

    always_comb begin
        prdata_o       = '0;
        pready_o       = 1'b0;
        pslverr_o      = 1'b0;
        ch_map_addr_o  = '0;
        ch_map_wen_o   = 1'b0;
        ch_map_data_o  = '0;
        col_map_addr_o = '0;
        col_map_wen_o  = 1'b0;
        col_map_data_o = '0;
        ch_t_rw_addr_o = '0;
        ch_t_rw_wen_o  = 1'b0;
        ch_t_rw_data_o = '0;
        unique case (r_state)
            ST_BYTE: begin
                if (r_region == RG_COL_MAP) begin
                    col_map_addr_o = w_map_addr;
                    col_map_wen_o  = r_write && r_strb[r_lane];
                    col_map_data_o = r_write ? w_lane_wbyte : 8'h00;
                end else begin
                    ch_map_addr_o  = w_map_addr;
                    ch_map_wen_o   = r_write && r_strb[r_lane];
                    ch_map_data_o  = r_write ? w_lane_wbyte : 8'h00;
                end
            end
            ST_GL_RD: ch_t_rw_addr_o = r_glyph;
            ST_GL_MRG: begin
                ch_t_rw_addr_o = r_glyph;
                ch_t_rw_wen_o  = r_write;
                ch_t_rw_data_o = r_write ? w_merge : 128'h0;
            end
            ST_RESP: begin
                pready_o  = 1'b1;
                pslverr_o = r_err;
                prdata_o  = r_write ? 32'h0 : r_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/apb_chargen_mem_ctrl.md
# apb_chargen_mem_ctrl

APB3/APB4 responder that gives a CPU read/write access to the three memories of the VGA text-mode generator: the character map, the colour map and the writable glyph table. It drives the A (CPU-side) port of each dual-port BRAM; the VGA scan logic independently reads the B ports. The block packs 8-bit map bytes into 32-bit APB words and performs read-modify-write on 128-bit glyph rows. Wait states are inserted by a small FSM.

## Interface
- ADDR_W, 14, APB address bits decoded (`paddr_i[13:0]`)
- CH_MAP_DEPTH, 2400, character/colour map entries (80×30)
- GLYPH_COUNT, 128, writable glyphs, 128 bits each (8×16)

- `clk_i`  in  1  system clock
- `arstn_i`  in  1  reset; one clock, asynchronous, active-low
- `psel_i`, `penable_i`, `pwrite_i`  in  1  APB control
- `paddr_i`  in  ADDR_W  byte address
- `pwdata_i`  in  32  write data
- `pstrb_i`  in  4  byte strobes
- `prdata_o`  out  32  read data
- `pready_o`, `pslverr_o`  out  1  APB response
- `ch_map_addr_o`  out  12  character map address
- `ch_map_wen_o`  out  1  character map write enable
- `ch_map_data_o`  out  8  character map write data
- `ch_map_data_i`  in  8  character map read data
- `col_map_addr_o`, `col_map_wen_o`, `col_map_data_o`, `col_map_data_i`  same as `ch_map_*`, colour map
- `ch_t_rw_addr_o`  out  7  glyph table address
- `ch_t_rw_wen_o`  out  1  glyph table write enable
- `ch_t_rw_data_o`  out  128  glyph table write data
- `ch_t_rw_data_i`  in  128  glyph table read data

## Operation
- **Address map** (`paddr_i[13:12]`):
  - 00: character map.
  - 01: colour map.
  - 10: glyph table; requires `paddr_i[11]`=0, else error.
  - 11: error.
  - `paddr_i[1:0]` is ignored.
- **Map regions:** word index W=`paddr_i[11:2]`.
  - W ≥ CH_MAP_DEPTH/4 (600) → error.
  - Byte lane k ↔ map address 4W+k ↔ `pwdata_i`/`prdata_o` bits [8k+7:8k] (little-endian).
- **Glyph region:** glyph G=`paddr_i[10:4]`, word w=`paddr_i[3:2]` ↔ row bits [32w+31:32w].
- **Memory ports:** all BRAM ports have synchronous read; data is valid the cycle after the address is presented.
- **FSM states:** IDLE, BYTE, BYTE_CAP, GL_RD, GL_MRG, RESP.
  - **IDLE:** on setup phase (`psel_i`=1, `penable_i`=0), latch addr/wdata/strb/write and decode.
    - Error → RESP with error flag.
    - Map → BYTE, lane=0.
    - Glyph → GL_RD.
  - **BYTE** (4 cycles, lane 0..3): drive map address 4W+lane.
    - Write: wen=1 only if `pstrb_i[lane]`; data = lane byte.
    - Read: data captured next cycle into lane−1.
    - After lane 3: write → RESP; read → BYTE_CAP (captures lane 3) → RESP.
  - **GL_RD:** drive address G, wen=0.
  - **GL_MRG:** `ch_t_rw_data_i` is valid.
    - Write: drive row with word w replaced per strobe, wen=1 for this cycle.
    - Read: latch word w.
    - Then → RESP.
  - **RESP:** `pready_o`=1 for one cycle; `pslverr_o`=error flag; `prdata_o`=assembled data on reads, else 0. Then → IDLE.
- **Memory port idle state:** only the addressed memory sees a non-zero address/wen. All wen are 0 outside BYTE/GL_MRG. Idle addresses/data are 0.
- **Errors:** no memory write occurs.
- **Glyph write with `pstrb_i`=0:** row is written back unchanged.
- **APB inputs after setup:** ignored until RESP. The sequence always runs to completion; the master must hold the transfer per APB.
- **Reset mid-operation:** FSM returns to IDLE immediately and all wen drop. Bytes already written persist; the pending transfer gets no response.

## Timing
- Setup phase in cycle T; `pready_o` high in:
  - T+1: error.
  - T+5: map write.
  - T+6: map read.
  - T+3: glyph read or write.
- `pready_o` is never high outside RESP. Back-to-back transfers: the next setup is accepted in the cycle after RESP.
- Reset values: all outputs 0, state IDLE.

## Structure
- `chargen_pkg`:
  - Region enum.
  - CH_MAP_DEPTH, GLYPH_COUNT, map/glyph address widths.
  - FSM state typedef.
- Sub-module `chargen_addr_decode` (combinational): `paddr_i` → region, index, lane base, error.

## Test plan
- **Map write, full strobe:** write 0x44332211 to 0x0004 → `ch_map_wen_o` pulses at addresses 4,5,6,7 with data 0x11,0x22,0x33,0x44; `pready_o` at T+5, `pslverr_o`=0.
- **Colour map partial strobe and readback:** write 0xAABBCCDD to 0x1000 with strobe 4'b0101, then read 0x1000 → colour addresses 0,2 written (0xDD,0xBB); read returns those bytes with prior content in lanes 1,3; `pready_o` at T+6.
- **Glyph RMW:** write 0xDEADBEEF to 0x2018 (G=1, w=2) → one GL_MRG write, row bits [95:64]=0xDEADBEEF, other bits preserved; read 0x2018 returns 0xDEADBEEF.
- **Errors:** access 0x0960 (W=600), 0x2800 and 0x3000 → `pready_o` and `pslverr_o` at T+1, no wen, `prdata_o`=0.
- **Reset mid-transfer:** assert `arstn_i`=0 during lane 2 of a map write → wen low asynchronously, lanes 0–1 written, lanes 2–3 not; the next transfer behaves normally.
